// File: rtl/regfile_writeback_queue_pkg.sv
// regfile_writeback_queue_pkg: shared widths and queue entry type for the register bank write-back queue
package regfile_writeback_queue_pkg;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NUM_REGS = 32;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_queue_bypass.sv
// wbq_bypass_match: age-ordered compare over queued entries, youngest matching entry wins
module wbq_bypass_match
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0] ent,
    input  logic      [DEPTH-1:0] vld,
    input  logic      [AW-1:0]    addr,
    output logic                  hit,
    output logic      [DW-1:0]    data
);
    always_comb begin
        hit = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && ent[i].addr == addr) begin
                hit = 1'b1;
                data = ent[i].data;
            end
        end
    end
endmodule

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: arbitrates ALU/load results into an in-order FIFO that retires to the register bank
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [AW-1:0]             alu_addr,
    input  logic [DW-1:0]             alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [AW-1:0]             mem_addr,
    input  logic [DW-1:0]             mem_data,
    output logic                      rf_write,
    output logic [AW-1:0]             rf_addr,
    output logic [DW-1:0]             rf_data,
    input  logic [AW-1:0]             byp_addr_1,
    output logic                      byp_hit_1,
    output logic [DW-1:0]             byp_data_1,
    input  logic [AW-1:0]             byp_addr_2,
    output logic                      byp_hit_2,
    output logic [DW-1:0]             byp_data_2,
    output logic [$clog2(DEPTH):0]    pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    wb_entry_t [DEPTH-1:0] mem_q, mem_d, ord;
    logic [DEPTH-1:0] vld;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rf_addr_q, rf_addr_d;
    logic [DW-1:0] rf_data_q, rf_data_d;
    logic full, push, pop;
    wb_entry_t in_e, nxt;
    // rf_* registers preload the entry that will sit at head after this edge, so retire costs no extra cycle
    always_comb begin
        full = count_q == CW'(DEPTH);
        mem_ready = ~full;
        alu_ready = ~full & ~mem_valid;
        push = (mem_valid | alu_valid) & ~full;
        pop = count_q != '0;
        in_e = mem_valid ? {mem_addr, mem_data} : {alu_addr, alu_data};
        mem_d = mem_q;
        if (push) mem_d[tail_q] = in_e;
        head_d = head_q + PW'(pop);
        tail_d = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
        nxt = mem_d[head_d];
        rf_addr_d = count_d != '0 ? nxt.addr : rf_addr_q;
        rf_data_d = count_d != '0 ? nxt.data : rf_data_q;
        for (int i = 0; i < DEPTH; i++) begin
            ord[i] = mem_q[head_q + PW'(i)];
            vld[i] = CW'(i) < count_q;
        end
        rf_write = pop & ~reset;
        rf_addr = rf_addr_q;
        rf_data = rf_data_q;
        pending = count_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            mem_q <= mem_d;
        end
    end
    wbq_bypass_match #(.DEPTH(DEPTH)) u_byp_1 (
        .ent(ord), .vld(vld), .addr(byp_addr_1), .hit(byp_hit_1), .data(byp_data_1)
    );
    wbq_bypass_match #(.DEPTH(DEPTH)) u_byp_2 (
        .ent(ord), .vld(vld), .addr(byp_addr_2), .hit(byp_hit_2), .data(byp_data_2)
    );
endmodule
